dot_prod_sched: RTL and testbench



---
 rtl/dot_prod_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_dot_prod_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_prod_sched.sv
// dot_prod_sched
//
// Shares one pipelined dot-product datapath among N_REQ requesters.
// A round-robin arbiter takes at most one input vector per cycle and
// registers it towards the datapath. A tag pipe records which requester
// each vector came from. Returning results are paired with their tag and
// queued in a first-word-fall-through result FIFO. Issue is limited by a
// credit count, so the FIFO can always absorb every result in flight.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req_valid      per-requester vector valid
//   o_req_ready      per-requester accept (one-hot or zero)
//   i_req_data       packed vectors, requester r at slice r
//   o_dp_valid       vector valid towards the datapath
//   o_dp_data        vector towards the datapath
//   i_dp_valid       datapath result valid
//   i_dp_data        datapath result
//   o_res_valid      result FIFO not empty
//   i_res_ready      consumer accepts the head result
//   o_res_data       head result
//   o_res_id         requester ID of the head result
//   o_busy           credit count non-zero
//   o_err            sticky protocol error (result/tag mismatch)

module dot_prod_sched #(
  parameter int N_REQ          = 4,
  parameter int N_IN           = 8,
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 38,
  parameter int DP_LATENCY     = 1,
  parameter int FIFO_DEPTH     = 4,
  localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int VEC_W         = N_IN * DATA_WIDTH_IN
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*VEC_W-1:0]    i_req_data,
  output logic                      o_dp_valid,
  output logic [VEC_W-1:0]          o_dp_data,
  input  logic                      i_dp_valid,
  input  logic [DATA_WIDTH_OUT-1:0] i_dp_data,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [DATA_WIDTH_OUT-1:0] o_res_data,
  output logic [ID_W-1:0]           o_res_id,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Architectural state
  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]             credit_q, credit_d;
  logic                      dp_valid_q, dp_valid_d;
  logic [VEC_W-1:0]          dp_data_q, dp_data_d;
  logic [ID_W-1:0]           dp_id_q, dp_id_d;
  logic [DP_LATENCY-1:0]     tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]           tag_id_q [DP_LATENCY];
  logic [ID_W-1:0]           tag_id_d [DP_LATENCY];
  logic [DATA_WIDTH_OUT-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH_OUT-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ID_W-1:0]           fifo_id_q [FIFO_DEPTH];
  logic [ID_W-1:0]           fifo_id_d [FIFO_DEPTH];
  logic [AW:0]               wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic                      err_q, err_d;

  // Combinational helpers
  logic                      credit_ok;
  logic [N_REQ-1:0]          grant_vec;
  logic                      grant_any;
  logic [ID_W-1:0]           grant_id;
  logic [ID_W-1:0]           arb_sel;
  int                        arb_idx;
  logic                      tag_out_valid;
  logic [ID_W-1:0]           tag_out_id;
  logic                      fifo_wr;
  logic                      tag_miss;
  logic                      tag_spurious;
  logic                      res_valid;
  logic                      res_pop;

  // A full credit count blocks issue even if a result is consumed in the
  // same cycle; the freed credit is only visible once registered. Gating
  // with i_rst_n keeps o_req_ready low while reset is asserted.
  assign credit_ok = (credit_q < CW'(FIFO_DEPTH)) && i_rst_n;

  // Round-robin search starting at the pointer; first valid requester wins.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    arb_idx   = 0;
    arb_sel   = '0;
    if (credit_ok) begin
      for (int i = 0; i < N_REQ; i++) begin
        arb_idx = int'(rr_ptr_q) + i;
        if (arb_idx >= N_REQ) begin
          arb_idx = arb_idx - N_REQ;
        end
        arb_sel = ID_W'(arb_idx);
        if (!grant_any && i_req_valid[arb_sel]) begin
          grant_any          = 1'b1;
          grant_id           = arb_sel;
          grant_vec[arb_sel] = 1'b1;
        end
      end
    end
  end

  assign tag_out_valid = tag_valid_q[DP_LATENCY-1];
  assign tag_out_id    = tag_id_q[DP_LATENCY-1];
  assign fifo_wr       = i_dp_valid && tag_out_valid;
  assign tag_miss      = tag_out_valid && !i_dp_valid;
  assign tag_spurious  = i_dp_valid && !tag_out_valid;
  assign res_valid     = (wr_ptr_q != rd_ptr_q);
  assign res_pop       = res_valid && i_res_ready;

  // Next-state for arbiter pointer, issue register, tag pipe and credits.
  // The tag pipe follows the issue register so its last stage lines up with
  // the datapath result DP_LATENCY cycles after o_dp_valid.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    dp_valid_d  = grant_any;
    dp_data_d   = dp_data_q;
    dp_id_d     = dp_id_q;
    tag_valid_d = tag_valid_q;
    tag_id_d    = tag_id_q;
    err_d       = err_q;

    if (grant_any) begin
      dp_data_d = i_req_data[int'(grant_id)*VEC_W +: VEC_W];
      dp_id_d   = grant_id;
      if (grant_id == ID_W'(N_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_id + ID_W'(1);
      end
    end

    tag_valid_d[0] = dp_valid_q;
    tag_id_d[0]    = dp_id_q;
    for (int k = 1; k < DP_LATENCY; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1];
      tag_id_d[k]    = tag_id_q[k-1];
    end

    if (tag_miss || tag_spurious) begin
      err_d = 1'b1;
    end

    // A missing result gives its credit back since nothing will be queued.
    credit_d = credit_q + CW'(grant_any) - CW'(res_pop) - CW'(tag_miss);
  end

  // Result FIFO: write at the tail and read at the head independently.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (fifo_wr) begin
      fifo_data_d[wr_ptr_q[AW-1:0]] = i_dp_data;
      fifo_id_d[wr_ptr_q[AW-1:0]]   = tag_out_id;
      wr_ptr_d                      = wr_ptr_q + (AW+1)'(1);
    end
    if (res_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q    <= '0;
      credit_q    <= '0;
      dp_valid_q  <= 1'b0;
      dp_data_q   <= '0;
      dp_id_q     <= '0;
      tag_valid_q <= '0;
      for (int k = 0; k < DP_LATENCY; k++) begin
        tag_id_q[k] <= '0;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_data_q[k] <= '0;
        fifo_id_q[k]   <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      dp_valid_q  <= dp_valid_d;
      dp_data_q   <= dp_data_d;
      dp_id_q     <= dp_id_d;
      tag_valid_q <= tag_valid_d;
      for (int k = 0; k < DP_LATENCY; k++) begin
        tag_id_q[k] <= tag_id_d[k];
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_data_q[k] <= fifo_data_d[k];
        fifo_id_q[k]   <= fifo_id_d[k];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
    end
  end

  assign o_req_ready = grant_vec;
  assign o_dp_valid  = dp_valid_q;
  assign o_dp_data   = dp_data_q;
  assign o_res_valid = res_valid;
  assign o_res_data  = fifo_data_q[rd_ptr_q[AW-1:0]];
  assign o_res_id    = fifo_id_q[rd_ptr_q[AW-1:0]];
  assign o_busy      = (credit_q != '0);
  assign o_err       = err_q;

endmodule

// File: tb/tb_dot_prod_sched.sv
// tb_dot_prod_sched
//
// Randomized bench for dot_prod_sched with a queue-based reference model.
// The bench also plays the datapath: one cycle after o_dp_valid it returns
// sum(x[k]*x[k+4], k=0..3), and can drop or inject responses on request.

module tb_dot_prod_sched;

  localparam int N_REQ = 4;
  localparam int N_IN  = 8;
  localparam int DW    = 16;
  localparam int DWO   = 38;
  localparam int FD    = 4;
  localparam int VW    = N_IN * DW;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic [N_REQ-1:0]      i_req_valid = '0;
  logic [N_REQ-1:0]      o_req_ready;
  logic [N_REQ*VW-1:0]   i_req_data = '0;
  logic                  o_dp_valid;
  logic [VW-1:0]         o_dp_data;
  logic                  i_dp_valid = 1'b0;
  logic [DWO-1:0]        i_dp_data = '0;
  logic                  o_res_valid;
  logic                  i_res_ready = 1'b0;
  logic [DWO-1:0]        o_res_data;
  logic [1:0]            o_res_id;
  logic                  o_busy;
  logic                  o_err;

  dot_prod_sched dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_data  (i_req_data),
    .o_dp_valid  (o_dp_valid),
    .o_dp_data   (o_dp_data),
    .i_dp_valid  (i_dp_valid),
    .i_dp_data   (i_dp_data),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_data  (o_res_data),
    .o_res_id    (o_res_id),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int     id;
    longint res;
    int     due;
  } item_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int req_vec [N_REQ][N_IN];

  // Reference model state
  int          m_rr;
  int          m_credits;
  bit          m_err;
  bit          m_dp_v;
  logic [VW-1:0] m_dp_data;
  item_t       m_pipe [$];
  item_t       m_fifo [$];

  // Bench datapath response scheduled for the next cycle
  bit             drv_v;
  logic [DWO-1:0] drv_d;

  // Compare one observed value against its expectation and tally it
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic packReqs();
    for (int r = 0; r < N_REQ; r++)
      for (int k = 0; k < N_IN; k++)
        i_req_data[(r*N_IN+k)*DW +: DW] = 16'(req_vec[r][k]);
  endtask

  task automatic randomizeReqs();
    for (int r = 0; r < N_REQ; r++)
      for (int k = 0; k < N_IN; k++)
        req_vec[r][k] = int'($urandom_range(0, 65535));
  endtask

  function automatic longint vecResult(input int r);
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(req_vec[r][k]) * longint'(req_vec[r][k+4]);
    return s;
  endfunction

  function automatic logic [DWO-1:0] dpModel(input logic [VW-1:0] v);
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(v[k*DW +: DW]) * longint'(v[(k+4)*DW +: DW]);
    return DWO'(s);
  endfunction

  function automatic int modelGrant(input logic [N_REQ-1:0] v);
    if (m_credits >= FD) return -1;
    for (int i = 0; i < N_REQ; i++) begin
      int idx = (m_rr + i) % N_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_rr      = 0;
    m_credits = 0;
    m_err     = 1'b0;
    m_dp_v    = 1'b0;
    m_dp_data = '0;
    m_pipe.delete();
    m_fifo.delete();
    drv_v     = 1'b0;
    drv_d     = '0;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge,
  // then advance the reference model across the next rising edge.
  task automatic applyStimulus(input logic [N_REQ-1:0] valid, input bit ready,
                               input bit randData, input bit drop, input bit inject);
    int g;
    bit cur_dp;
    logic [N_REQ-1:0] exp_rdy;
    item_t it;
    @(posedge i_clk);
    #1;
    cyc++;
    if (randData) randomizeReqs();
    packReqs();
    i_req_valid = valid;
    i_res_ready = ready;
    i_dp_valid  = drv_v;
    i_dp_data   = drv_d;
    cur_dp      = drv_v;
    @(negedge i_clk);

    g = modelGrant(valid);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checkOutput("req_ready", 64'(o_req_ready), 64'(exp_rdy));
    checkOutput("dp_valid", 64'(o_dp_valid), 64'(m_dp_v));
    checkOutput("dp_data_lo", o_dp_data[63:0], m_dp_data[63:0]);
    checkOutput("dp_data_hi", o_dp_data[127:64], m_dp_data[127:64]);
    checkOutput("res_valid", 64'(o_res_valid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      checkOutput("res_data", 64'(o_res_data), 64'(m_fifo[0].res));
      checkOutput("res_id", 64'(o_res_id), 64'(m_fifo[0].id));
    end
    checkOutput("busy", 64'(o_busy), 64'(m_credits != 0));
    checkOutput("err", 64'(o_err), 64'(m_err));

    drv_v = (o_dp_valid && !drop) || inject;
    drv_d = dpModel(o_dp_data);

    if (m_fifo.size() > 0 && ready) begin
      void'(m_fifo.pop_front());
      m_credits--;
    end
    if (m_pipe.size() > 0 && m_pipe[0].due == cyc) begin
      it = m_pipe.pop_front();
      if (cur_dp) m_fifo.push_back(it);
      else begin
        m_err = 1'b1;
        m_credits--;
      end
    end else if (cur_dp) begin
      m_err = 1'b1;
    end
    if (g >= 0) begin
      m_credits++;
      m_rr   = (g + 1) % N_REQ;
      it.id  = g;
      it.res = vecResult(g);
      it.due = cyc + 2;
      m_pipe.push_back(it);
      m_dp_v = 1'b1;
      for (int k = 0; k < N_IN; k++) m_dp_data[k*DW +: DW] = 16'(req_vec[g][k]);
    end else begin
      m_dp_v = 1'b0;
    end
  endtask

  task automatic resetOutputsZero(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
    checkOutput({tag, "_res_valid"}, 64'(o_res_valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(o_busy), 64'd0);
    checkOutput({tag, "_dp_valid"}, 64'(o_dp_valid), 64'd0);
    checkOutput({tag, "_dp_data"}, o_dp_data[63:0] | o_dp_data[127:64], 64'd0);
    checkOutput({tag, "_err"}, 64'(o_err), 64'd0);
  endtask

  // Assert reset mid-cycle with random inputs, release at a falling edge
  task automatic doReset();
    @(posedge i_clk);
    #1;
    i_rst_n     = 1'b0;
    i_req_valid = N_REQ'($urandom_range(1, 15));
    randomizeReqs();
    packReqs();
    i_res_ready = 1'b1;
    i_dp_valid  = 1'b1;
    i_dp_data   = DWO'({$urandom, $urandom});
    #1;
    resetOutputsZero("rst_now");
    repeat (2) begin
      @(posedge i_clk);
      #1;
      i_req_valid = N_REQ'($urandom_range(1, 15));
      i_dp_valid  = 1'($urandom);
      i_res_ready = 1'($urandom);
    end
    @(negedge i_clk);
    resetOutputsZero("rst_hold");
    modelReset();
    i_req_valid = '0;
    i_dp_valid  = 1'b0;
    i_res_ready = 1'b0;
    i_rst_n     = 1'b1;
  endtask

  initial begin
    modelReset();
    randomizeReqs();
    doReset();

    // First request after release is granted in the same cycle
    applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_first_grant", 64'(o_req_ready), 64'h4);
    repeat (4) applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Single request with the vector 1..8, result 70 from requester 1
    for (int k = 0; k < N_IN; k++) req_vec[1][k] = k + 1;
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("single_grant", 64'(o_req_ready), 64'h2);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("single_dp_valid", 64'(o_dp_valid), 64'd1);
    checkOutput("single_dp_elem7", 64'(o_dp_data[7*DW +: DW]), 64'd8);
    checkOutput("single_busy_t1", 64'(o_busy), 64'd1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("single_res_early", 64'(o_res_valid), 64'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("single_res_valid", 64'(o_res_valid), 64'd1);
    checkOutput("single_res_data", 64'(o_res_data), 64'd70);
    checkOutput("single_res_id", 64'(o_res_id), 64'd1);
    checkOutput("single_busy_t3", 64'(o_busy), 64'd1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("single_busy_t4", 64'(o_busy), 64'd0);

    // Round robin with all requesters valid and the consumer always ready
    repeat (24) applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: credits run out, then a one-cycle pop frees one grant
    repeat (8) applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_stalled", 64'(o_req_ready), 64'd0);
    checkOutput("bp_fifo_full_valid", 64'(o_res_valid), 64'd1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_pop_no_grant", 64'(o_req_ready), 64'd0);
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_one_regrant", 64'($countones(o_req_ready)), 64'd1);
    applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_stalled_again", 64'(o_req_ready), 64'd0);
    repeat (8) applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Spurious datapath result with nothing issued
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("spur_err", 64'(o_err), 64'd1);
    checkOutput("spur_fifo_empty", 64'(o_res_valid), 64'd0);
    checkOutput("spur_busy", 64'(o_busy), 64'd0);
    repeat (3) applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("spur_err_sticky", 64'(o_err), 64'd1);

    // Suppressed datapath response: error raised and credit released
    doReset();
    applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("drop_err", 64'(o_err), 64'd1);
    checkOutput("drop_busy", 64'(o_busy), 64'd0);
    checkOutput("drop_res_valid", 64'(o_res_valid), 64'd0);

    // Reset with three results buffered and one in flight
    doReset();
    repeat (6) applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_busy", 64'(o_busy), 64'd1);
    doReset();
    randomizeReqs();
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_grant", 64'(o_req_ready), 64'h8);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_res_valid", 64'(o_res_valid), 64'd1);
    checkOutput("post_rst_res_id", 64'(o_res_id), 64'd3);
    checkOutput("post_rst_res_data", 64'(o_res_data), 64'(vecResult(3)));

    // Random soak
    repeat (300) applyStimulus(N_REQ'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                               1'b1, 1'b0, 1'b0);
    repeat (10) applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("final_idle", 64'(o_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
